clk_switch_seq: RTL and testbench

CLK_SWITCH_SEQ -- requirements
Module: clk_switch_seq

---
 rtl/clk_switch_seq.sv | 192 +++++++++++++++++++
 tb/tb_clk_switch_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_seq.sv
// Clock-source switch sequencer: reset hold, source change, MMCM re-lock, frequency check, bounded retries.
// Timed states last exactly their parameter count; switch_req is only honoured in IDLE or FAIL.
module clk_switch_seq #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int SETTLE_CYCLES       = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MEAS_CYCLES         = 65536,
  parameter int MEAS_SETTLE_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic        pl_clk0_i,
  input  logic        pl_reset_n_i,
  input  logic        switch_req_i,
  input  logic        switch_sel_i,
  input  logic [23:0] fmeas_min_i,
  input  logic [23:0] fmeas_max_i,
  input  logic        clk_locked_i,
  input  logic [23:0] fmeas_count_i,
  output logic        clk_reset_o,
  output logic        sys_reset_o,
  output logic        clkin_src_sel_o,
  output logic        fmeas_enable_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [1:0]  retry_count_o,
  output logic [23:0] meas_count_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(RST_HOLD_CYCLES, SETTLE_CYCLES),
                             max2(max2(LOCK_TIMEOUT_CYCLES, MEAS_CYCLES), MEAS_SETTLE_CYCLES));
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] MEAS_LAST   = TW'(MEAS_CYCLES - 1);
  localparam logic [TW-1:0] MSET_LAST   = TW'(MEAS_SETTLE_CYCLES - 1);
  localparam logic [1:0]    MAX_R       = 2'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, SWITCH, RELEASE, WAIT_LOCK,
    MEASURE, SAMPLE, CHECK, RUN, FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          target_q, target_d;
  logic          src_q, src_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    err_q, err_d;
  logic [23:0]   meas_q, meas_d;
  logic          fail;
  logic [1:0]    cause;
  logic          in_window;

  assign in_window = (meas_q >= fmeas_min_i) && (meas_q <= fmeas_max_i);

  always_ff @(posedge pl_clk0_i) begin
    if (!pl_reset_n_i) begin
      state_q  <= ASSERT_RST;
      timer_q  <= '0;
      target_q <= 1'b0;
      src_q    <= 1'b0;
      retry_q  <= 2'd0;
      err_q    <= 2'd0;
      meas_q   <= 24'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      src_q    <= src_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      meas_q   <= meas_d;
    end
  end

  // Timer only advances while staying in a timed state, so it never wraps.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    target_d = target_q;
    src_d    = src_q;
    retry_d  = retry_q;
    err_d    = err_q;
    meas_d   = meas_q;
    fail     = 1'b0;
    cause    = 2'd0;
    case (state_q)
      IDLE, FAIL: begin
        if (switch_req_i) begin
          target_d = switch_sel_i;
          retry_d  = 2'd0;
          err_d    = 2'd0;
          state_d  = ASSERT_RST;
        end else if (state_q == IDLE && !clk_locked_i) begin
          target_d = src_q;
          retry_d  = 2'd0;
          err_d    = 2'd3;
          state_d  = ASSERT_RST;
        end
      end
      ASSERT_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = SWITCH;
          src_d   = target_q;
        end else timer_d = timer_q + 1'b1;
      end
      SWITCH: begin
        if (timer_q == SETTLE_LAST) state_d = RELEASE;
        else timer_d = timer_q + 1'b1;
      end
      RELEASE: state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (clk_locked_i) state_d = MEASURE;
        else if (timer_q == LOCK_LAST) begin
          fail  = 1'b1;
          cause = 2'd1;
        end else timer_d = timer_q + 1'b1;
      end
      MEASURE, SAMPLE, CHECK, RUN: begin
        if (!clk_locked_i) begin
          fail  = 1'b1;
          cause = 2'd3;
        end else if (state_q == MEASURE) begin
          if (timer_q == MEAS_LAST) state_d = SAMPLE;
          else timer_d = timer_q + 1'b1;
        end else if (state_q == SAMPLE) begin
          if (timer_q == MSET_LAST) begin
            meas_d  = fmeas_count_i;
            state_d = CHECK;
          end else timer_d = timer_q + 1'b1;
        end else if (state_q == CHECK) begin
          if (in_window) state_d = RUN;
          else begin
            fail  = 1'b1;
            cause = 2'd2;
          end
        end else state_d = IDLE;
      end
      default: state_d = ASSERT_RST;
    endcase
    if (fail) begin
      err_d = cause;
      if (retry_q < MAX_R) begin
        retry_d = retry_q + 2'd1;
        state_d = ASSERT_RST;
      end else begin
        state_d = FAIL;
      end
    end
  end

  always_comb begin
    clk_reset_o    = 1'b0;
    sys_reset_o    = 1'b1;
    fmeas_enable_o = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    error_o        = 1'b0;
    case (state_q)
      ASSERT_RST, SWITCH: clk_reset_o = 1'b1;
      MEASURE:            fmeas_enable_o = 1'b1;
      RUN: begin
        sys_reset_o = 1'b0;
        done_o      = clk_locked_i;
      end
      IDLE: begin
        sys_reset_o = 1'b0;
        busy_o      = 1'b0;
      end
      FAIL: begin
        clk_reset_o = 1'b1;
        busy_o      = 1'b0;
        error_o     = 1'b1;
      end
      default: ;
    endcase
  end

  assign clkin_src_sel_o = src_q;
  assign err_code_o      = err_q;
  assign retry_count_o   = retry_q;
  assign meas_count_o    = meas_q;

endmodule

// File: tb/tb_clk_switch_seq.sv
// Scoreboard bench for clk_switch_seq with a simple MMCM lock model.
module tb_clk_switch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        switch_req, switch_sel;
  logic [23:0] fmeas_min, fmeas_max, fcount;
  logic        clk_locked;
  logic        clk_reset, sys_reset, clkin_src_sel, fmeas_enable, busy, done, error;
  logic [1:0]  err_code, retry_count;
  logic [23:0] meas_count;

  always #5 clk = ~clk;

  clk_switch_seq #(
    .RST_HOLD_CYCLES(4), .SETTLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(50),
    .MEAS_CYCLES(100), .MEAS_SETTLE_CYCLES(2), .MAX_RETRIES(2)
  ) dut (
    .pl_clk0_i(clk), .pl_reset_n_i(rst_n), .switch_req_i(switch_req), .switch_sel_i(switch_sel),
    .fmeas_min_i(fmeas_min), .fmeas_max_i(fmeas_max), .clk_locked_i(clk_locked),
    .fmeas_count_i(fcount), .clk_reset_o(clk_reset), .sys_reset_o(sys_reset),
    .clkin_src_sel_o(clkin_src_sel), .fmeas_enable_o(fmeas_enable), .busy_o(busy),
    .done_o(done), .error_o(error), .err_code_o(err_code), .retry_count_o(retry_count),
    .meas_count_o(meas_count)
  );

  // MMCM model: lock drops while clk_reset is high, returns lock_dly cycles after release.
  logic mdl_lock = 1'b0;
  int   lock_cnt = 0;
  int   lock_dly = 10;
  logic lock_en = 1'b1;
  logic force_low = 1'b0;
  always @(negedge clk) begin
    if (clk_reset || !lock_en) begin
      lock_cnt = 0;
      mdl_lock = 1'b0;
    end else if (lock_cnt >= lock_dly) mdl_lock = 1'b1;
    else lock_cnt++;
  end
  assign clk_locked = mdl_lock & ~force_low;

  typedef struct {
    logic        is_fail;
    logic [23:0] meas;
    logic        src;
    logic [1:0]  err;
    logic [1:0]  retry;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic f, input logic [23:0] m, input logic s,
                          input logic [1:0] e, input logic [1:0] r);
    exp_t x;
    x.is_fail = f; x.meas = m; x.src = s; x.err = e; x.retry = r;
    exp_q.push_back(x);
  endtask

  task automatic issue_req(input logic sel);
    switch_sel = sel;
    switch_req = 1'b1;
    @(negedge clk);
    switch_req = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_clk_reset"}, clk_reset, 1);
    check_val({tag, "_sys_reset"}, sys_reset, 1);
    check_val({tag, "_src_sel"}, clkin_src_sel, 0);
    check_val({tag, "_fmeas_en"}, fmeas_enable, 0);
    check_val({tag, "_busy"}, busy, 1);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_error"}, error, 0);
    check_val({tag, "_err_code"}, err_code, 0);
    check_val({tag, "_retry"}, retry_count, 0);
    check_val({tag, "_meas"}, meas_count, 0);
  endtask

  // Waits for done or FAIL, counting clk_reset cycles before/after the source change.
  task automatic wait_outcome(input string tag, input int budget, output int n_pre,
                              output int n_post, output int n_fen, output int n_smp);
    exp_t e;
    logic seen;
    n_pre = 0; n_post = 0; n_fen = 0; n_smp = 0; seen = 1'b0;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_depth"}, 0, 1);
      return;
    end
    e = exp_q[0];
    for (int i = 1; i <= budget; i++) begin
      if (done || error) begin
        seen = 1'b1;
        n_smp = i;
        break;
      end
      if (clk_reset && clkin_src_sel != e.src) n_pre++;
      if (clk_reset && clkin_src_sel == e.src) n_post++;
      if (fmeas_enable) n_fen++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check_val({tag, "_outcome_seen"}, seen, 1);
    if (seen) begin
      check_val({tag, "_is_fail"}, error, e.is_fail);
      check_val({tag, "_meas"}, meas_count, e.meas);
      check_val({tag, "_src"}, clkin_src_sel, e.src);
      check_val({tag, "_err_code"}, err_code, e.err);
      check_val({tag, "_retry"}, retry_count, e.retry);
      if (e.is_fail) begin
        check_val({tag, "_fail_clk_reset"}, clk_reset, 1);
        check_val({tag, "_fail_sys_reset"}, sys_reset, 1);
        check_val({tag, "_fail_busy"}, busy, 0);
      end else begin
        check_val({tag, "_run_sys_reset"}, sys_reset, 0);
        @(negedge clk);
        check_val({tag, "_done_width"}, done, 0);
        check_val({tag, "_idle_busy"}, busy, 0);
        check_val({tag, "_idle_sys_reset"}, sys_reset, 0);
      end
    end
  endtask

  task automatic wait_err(input string tag, input logic [1:0] code, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (err_code == code) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val({tag, "_err_reached"}, ok, 1);
  endtask

  int pre, post, fen, smp;
  logic ok;

  initial begin
    rst_n = 1'b0; switch_req = 1'b0; switch_sel = 1'b0;
    fmeas_min = 24'd990; fmeas_max = 24'd1010; fcount = 24'd1000;
    repeat (3) @(negedge clk);
    reset_checks("por");

    // Boot to source 0 without a request.
    push_exp(1'b0, 24'd1000, 1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
    wait_outcome("boot", 400, pre, post, fen, smp);
    check_val("boot_fen_cycles", fen, 100);

    // Switch to source 1: 4 cycles of clk_reset before the change, 8 after.
    push_exp(1'b0, 24'd1000, 1'b1, 2'd0, 2'd0);
    issue_req(1'b1);
    wait_outcome("sw1", 400, pre, post, fen, smp);
    check_val("sw1_rst_before_sel", pre, 4);
    check_val("sw1_rst_after_sel", post, 8);
    check_val("sw1_fen_cycles", fen, 100);

    // Lock never arrives: three 63-cycle attempts, FAIL seen on sample 190.
    push_exp(1'b1, 24'd1000, 1'b0, 2'd1, 2'd2);
    issue_req(1'b0);
    lock_en = 1'b0;
    wait_outcome("lockto", 400, pre, post, fen, smp);
    check_val("lockto_fail_entry_cycle", smp, 190);
    lock_en = 1'b1;
    push_exp(1'b0, 24'd1000, 1'b0, 2'd0, 2'd0);
    issue_req(1'b0);
    check_val("recover_error_cleared", error, 0);
    check_val("recover_err_code_cleared", err_code, 0);
    check_val("recover_retry_cleared", retry_count, 0);
    check_val("recover_busy", busy, 1);
    wait_outcome("recover", 400, pre, post, fen, smp);

    // Upper bound: 1011 rejected, 1010 accepted on retry.
    fcount = 24'd1011;
    push_exp(1'b0, 24'd1010, 1'b1, 2'd2, 2'd1);
    issue_req(1'b1);
    wait_err("hi", 2'd2, 400);
    fcount = 24'd1010;
    wait_outcome("hi", 400, pre, post, fen, smp);

    // Lower bound: 989 rejected, 990 accepted on retry.
    fcount = 24'd989;
    push_exp(1'b0, 24'd990, 1'b0, 2'd2, 2'd1);
    issue_req(1'b0);
    wait_err("lo", 2'd2, 400);
    fcount = 24'd990;
    wait_outcome("lo", 400, pre, post, fen, smp);

    // Lock lost in IDLE: re-lock to the unchanged source.
    fcount = 24'd1000;
    push_exp(1'b0, 24'd1000, 1'b0, 2'd3, 2'd0);
    force_low = 1'b1;
    @(negedge clk);
    force_low = 1'b0;
    check_val("drop_sys_reset", sys_reset, 1);
    check_val("drop_err_code", err_code, 3);
    check_val("drop_busy", busy, 1);
    check_val("drop_clk_reset", clk_reset, 1);
    wait_outcome("drop", 400, pre, post, fen, smp);

    // Request during MEASURE is ignored.
    push_exp(1'b0, 24'd1000, 1'b1, 2'd0, 2'd0);
    issue_req(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fmeas_enable) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("ign_reach_measure", ok, 1);
    issue_req(1'b0);
    check_val("ign_still_measuring", fmeas_enable, 1);
    wait_outcome("ign", 400, pre, post, fen, smp);

    // Same source again still runs the full sequence.
    push_exp(1'b0, 24'd1000, 1'b1, 2'd0, 2'd0);
    issue_req(1'b1);
    wait_outcome("same", 400, pre, post, fen, smp);
    check_val("same_rst_cycles", post, 12);
    check_val("same_fen_cycles", fen, 100);

    // Reset applied in WAIT_LOCK restarts the boot sequence.
    issue_req(1'b1);
    lock_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!clk_reset) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("mid_reached_release", ok, 1);
    repeat (5) @(negedge clk);
    check_val("mid_src_before_reset", clkin_src_sel, 1);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("mid");
    push_exp(1'b0, 24'd1000, 1'b0, 2'd0, 2'd0);
    lock_en = 1'b1;
    rst_n = 1'b1;
    wait_outcome("reboot", 400, pre, post, fen, smp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
